instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the RV32I core. Owns the program counter and drives the

---
 rtl/instr_fetch_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// RV32I fetch sequencer: owns the PC, reads the combinational instruction memory
// and hands fetched words to decode through a small in-order queue.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] PC_LIMIT   = 32'd92,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted,
  output logic        misalign_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s, pc_plus4_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [31:0]   mem_pc_r    [FIFO_DEPTH];
  logic [31:0]   mem_instr_r [FIFO_DEPTH];
  logic          id_valid_r, head_valid_s;
  logic [31:0]   id_instr_r, head_instr_s;
  logic [31:0]   id_pc_r, head_pc_s;
  logic          halted_r, halted_nxt_s;
  logic          misalign_r, misalign_nxt_s;
  logic          push_s, pop_s, flush_s;

  assign pop_s      = id_valid_r && id_ready;
  assign pc_plus4_s = pc_r + 32'd4;

  // Sequencer next state: redirect outranks fetch, ERROR only leaves via reset.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    push_s         = 1'b0;
    flush_s        = 1'b0;
    misalign_nxt_s = misalign_r;
    if (redirect_valid && (state_r != ST_ERROR)) begin
      flush_s  = 1'b1;
      pc_nxt_s = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_nxt_s    = ST_ERROR;
        misalign_nxt_s = 1'b1;
      end else if (redirect_pc >= PC_LIMIT) begin
        state_nxt_s = ST_HALT;
      end else begin
        state_nxt_s = ST_FETCH;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (pc_r >= PC_LIMIT) begin
            state_nxt_s = ST_HALT;
          end else if ((count_r < DEPTH_C) || pop_s) begin
            push_s   = 1'b1;
            pc_nxt_s = pc_plus4_s;
            if (pc_plus4_s >= PC_LIMIT) begin
              state_nxt_s = ST_HALT;
            end else begin
              state_nxt_s = ST_FETCH;
            end
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        ST_ERROR: begin
          state_nxt_s    = ST_ERROR;
          misalign_nxt_s = 1'b1;
        end
        default: begin
          // Corrupted state encoding: park safely with an empty queue.
          state_nxt_s    = ST_ERROR;
          flush_s        = 1'b1;
          misalign_nxt_s = 1'b1;
        end
      endcase
    end
  end

  // Queue pointer and occupancy update.
  always_comb begin
    count_nxt_s  = count_r;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    if (flush_s) begin
      count_nxt_s  = {CW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      wr_ptr_nxt_s = {PW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (push_s && !pop_s) begin
        count_nxt_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_nxt_s = count_r - CNT_ONE;
      end else begin
        count_nxt_s = count_r;
      end
    end
  end

  // Head of the queue after this edge; a word pushed into an empty slot
  // at the new read pointer bypasses storage so the outputs stay registered.
  always_comb begin
    head_valid_s = 1'b0;
    head_pc_s    = 32'd0;
    head_instr_s = 32'd0;
    if (count_nxt_s == {CW{1'b0}}) begin
      head_valid_s = 1'b0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_valid_s = 1'b1;
      head_pc_s    = pc_r;
      head_instr_s = imem_instr;
    end else begin
      head_valid_s = 1'b1;
      head_pc_s    = mem_pc_r[rd_ptr_nxt_s];
      head_instr_s = mem_instr_r[rd_ptr_nxt_s];
    end
  end

  assign halted_nxt_s = (state_nxt_s == ST_HALT) && (count_nxt_s == {CW{1'b0}});

  // State, PC, queue control and registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= RESET_PC;
      count_r    <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      id_valid_r <= 1'b0;
      id_instr_r <= 32'd0;
      id_pc_r    <= 32'd0;
      halted_r   <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      count_r    <= count_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      id_valid_r <= head_valid_s;
      id_instr_r <= head_instr_s;
      id_pc_r    <= head_pc_s;
      halted_r   <= halted_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_r[i]    <= 32'd0;
        mem_instr_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]    <= pc_r;
      mem_instr_r[wr_ptr_r] <= imem_instr;
    end
  end

  assign imem_pc      = pc_r;
  assign id_valid     = id_valid_r;
  assign id_instr     = id_instr_r;
  assign id_pc        = id_pc_r;
  assign halted       = halted_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] LIMIT = 32'd92;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;
  logic        misalign_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: fetched words in order, the PC, and a mode (0 fetch, 1 halt, 2 error).
  entry_t      mq[$];
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_err;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   rom = 32'h00940333;
      32'd4:   rom = 32'h800100b3;
      32'd68:  rom = 32'h00410063;
      32'd88:  rom = 32'h000080ef;
      default: rom = {a[15:0], 16'h0513} ^ 32'h5a5a_0000;
    endcase
  endfunction

  assign imem_instr = rom(imem_pc);

  instr_fetch_ctrl #(
    .RESET_PC   (32'd0),
    .PC_LIMIT   (LIMIT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .halted         (halted),
    .misalign_err   (misalign_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit     pop_b;
    bit     room_b;
    entry_t e;
    if (!reset) begin
      mq.delete();
      m_pc   = 32'd0;
      m_mode = 0;
      m_err  = 1'b0;
    end else begin
      pop_b  = (mq.size() > 0) && id_ready;
      room_b = (mq.size() < DEPTH) || pop_b;
      if (redirect_valid && m_mode != 2) begin
        mq.delete();
        m_pc = redirect_pc;
        if ((redirect_pc % 32'd4) != 32'd0) begin
          m_mode = 2;
          m_err  = 1'b1;
        end else if (redirect_pc >= LIMIT) begin
          m_mode = 1;
        end else begin
          m_mode = 0;
        end
      end else begin
        if (pop_b) void'(mq.pop_front());
        if (m_mode == 0) begin
          if (m_pc >= LIMIT) begin
            m_mode = 1;
          end else if (room_b) begin
            e.pc    = m_pc;
            e.instr = rom(m_pc);
            mq.push_back(e);
            m_pc = m_pc + 32'd4;
            if (m_pc >= LIMIT) m_mode = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ein;
    ev  = (mq.size() > 0);
    epc = ev ? mq[0].pc : 32'd0;
    ein = ev ? mq[0].instr : 32'd0;
    check_eq("imem_pc", imem_pc, m_pc);
    check_eq("id_valid", 32'(id_valid), 32'(ev));
    check_eq("id_pc", id_pc, epc);
    check_eq("id_instr", id_instr, ein);
    check_eq("halted", 32'(halted), 32'((m_mode == 1) && (mq.size() == 0)));
    check_eq("misalign_err", 32'(misalign_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic [31:0] r;
    int          err_cycles;

    reset          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset values
    tick();
    tick();
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_imem_pc", imem_pc, 32'd0);
    check_eq("rst_id_instr", id_instr, 32'd0);

    // 1: streaming with decode always ready
    reset    = 1'b1;
    id_ready = 1'b1;
    tick();
    check_eq("t1_id_pc0", id_pc, 32'd0);
    check_eq("t1_id_instr0", id_instr, 32'h00940333);
    tick();
    check_eq("t1_id_pc4", id_pc, 32'd4);
    check_eq("t1_id_instr4", id_instr, 32'h800100b3);
    for (int i = 0; i < 3; i++) tick();
    check_eq("t1_id_pc16", id_pc, 32'd16);

    // 2: back-pressure fills the queue, then drains in order
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("t2_imem_pc_stall", imem_pc, 32'd16);
    check_eq("t2_head_pc", id_pc, 32'd0);
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("t2_drain_pc", id_pc, 32'(4 * i));
    end

    // 3: redirect with three entries queued
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'd68;
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_flush_valid", 32'(id_valid), 32'd0);
    tick();
    check_eq("t3_target_pc", id_pc, 32'd68);
    check_eq("t3_target_instr", id_instr, 32'h00410063);

    // 4: run to the end of the program, drain, then restart from HALT
    id_ready   = 1'b1;
    last_pc    = 32'hFFFF_FFFF;
    last_instr = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      if (id_valid && id_ready) begin
        last_pc    = id_pc;
        last_instr = id_instr;
      end
      tick();
      if (halted) break;
    end
    check_eq("t4_halted", 32'(halted), 32'd1);
    check_eq("t4_last_pc", last_pc, 32'd88);
    check_eq("t4_last_instr", last_instr, 32'h000080ef);
    check_eq("t4_imem_pc_hold", imem_pc, 32'd92);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("t4_resume_pc", id_pc, 32'd0);
    check_eq("t4_resume_halted", 32'(halted), 32'd0);

    // 5: misaligned redirect locks into the error state
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    check_eq("t5_misalign", 32'(misalign_err), 32'd1);
    check_eq("t5_id_valid", 32'(id_valid), 32'd0);
    redirect_pc = 32'd8;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b0;
    check_eq("t5_pc_frozen", imem_pc, 32'h42);
    check_eq("t5_sticky", 32'(misalign_err), 32'd1);

    // 6: reset wins over a same-cycle redirect with a full queue
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    id_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd68;
    tick();
    check_eq("t6_id_valid", 32'(id_valid), 32'd0);
    check_eq("t6_imem_pc", imem_pc, 32'd0);
    check_eq("t6_misalign", 32'(misalign_err), 32'd0);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick();
    check_eq("t6_restart_pc", id_pc, 32'd0);

    // Random traffic against the model
    err_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b1;
      if (err_cycles > 8 || $urandom_range(0, 199) == 0) reset = 1'b0;
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      r              = 32'($urandom_range(0, 107));
      redirect_pc    = ($urandom_range(0, 29) == 0) ? r : (r & 32'hFFFF_FFFC);
      tick();
      err_cycles = (m_mode == 2) ? err_cycles + 1 : 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
